// File: rtl/mips_isa_pkg.sv
// Shared definitions for the MIPS I-type immediate execution unit:
// opcodes, status bit positions and the decoded-operation enum.
package mips_isa_pkg;

   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_SLTI  = 6'h0A;
   localparam logic [5:0] OPC_SLTIU = 6'h0B;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_XORI  = 6'h0E;
   localparam logic [5:0] OPC_LUI   = 6'h0F;

   localparam int ST_ZERO   = 0;
   localparam int ST_NEG    = 1;
   localparam int ST_OVF    = 2;
   localparam int ST_CARRY  = 3;
   localparam int ST_TAKEN  = 4;
   localparam int ST_ILL    = 5;
   localparam int ST_WR     = 6;
   localparam int ST_STICKY = 7;

   typedef enum logic [3:0] {
      OP_ADD, OP_ADDU, OP_SLT, OP_SLTU, OP_AND, OP_OR,
      OP_XOR, OP_LUI, OP_BEQ, OP_BNE, OP_ILL
   } op_e;

   function automatic op_e decode_op(input logic [5:0] opc);
      op_e op;
      case (opc)
         OPC_ADDI:  op = OP_ADD;
         OPC_ADDIU: op = OP_ADDU;
         OPC_SLTI:  op = OP_SLT;
         OPC_SLTIU: op = OP_SLTU;
         OPC_ANDI:  op = OP_AND;
         OPC_ORI:   op = OP_OR;
         OPC_XORI:  op = OP_XOR;
         OPC_LUI:   op = OP_LUI;
         OPC_BEQ:   op = OP_BEQ;
         OPC_BNE:   op = OP_BNE;
         default:   op = OP_ILL;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mips_regfile.sv
// NUM_REGS x DATA_W register file: two async read ports, one debug read
// port, one synchronous write port; register 0 always reads as zero.
module mips_regfile
   import mips_isa_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [4:0]        rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              we,
   input  logic [4:0]        wa,
   input  logic [DATA_W-1:0] wd
);

   localparam int AW = $clog2(NUM_REGS);

   logic [DATA_W-1:0] regs [NUM_REGS];

   function automatic logic valid_idx(input logic [4:0] a);
      return (a != 5'd0) && (int'(a) < NUM_REGS);
   endfunction

   always_comb begin
      ra_data  = valid_idx(ra_addr)  ? regs[ra_addr[AW-1:0]]  : '0;
      rb_data  = valid_idx(rb_addr)  ? regs[rb_addr[AW-1:0]]  : '0;
      dbg_data = valid_idx(dbg_addr) ? regs[dbg_addr[AW-1:0]] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we && valid_idx(wa)) begin
         regs[wa[AW-1:0]] <= wd;
      end
   end

endmodule

// File: rtl/mips_imm_exec_unit.sv
// Executes MIPS I-type immediate and beq/bne instructions against an internal
// register file, with a 1-deep valid/ready output stage and trap accounting.
module mips_imm_exec_unit
   import mips_isa_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       machinecode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic [7:0]        status,
   output logic [CNT_W-1:0]  retired_cnt,
   output logic [CNT_W-1:0]  trap_cnt,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [5:0]  opcode;
   logic [4:0]  rs, rt;
   logic [15:0] imm;
   assign opcode = machinecode[31:26];
   assign rs     = machinecode[25:21];
   assign rt     = machinecode[20:16];
   assign imm    = machinecode[15:0];

   logic [DATA_W-1:0] rs_val, rt_val;
   logic [DATA_W-1:0] imm_s, imm_z, lui_val;
   logic [DATA_W:0]   sum;
   logic signed [15:0] imm_sgn;
   logic signed [31:0] lui32;

   op_e               op;
   logic              illegal, accept, wen_c, taken_c, ovf_c, carry_c, add_ovf;
   logic [DATA_W-1:0] res_c;
   logic [7:0]        status_c;
   logic              sticky_q;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   mips_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra_addr  (rs),
      .ra_data  (rs_val),
      .rb_addr  (rt),
      .rb_data  (rt_val),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (accept && wen_c),
      .wa       (rt),
      .wd       (res_c)
   );

   assign imm_sgn = imm;
   assign lui32   = {imm, 16'h0000};
   assign imm_s   = DATA_W'(imm_sgn);
   assign imm_z   = DATA_W'(imm);
   assign lui_val = DATA_W'(lui32);
   assign sum     = {1'b0, rs_val} + {1'b0, imm_s};
   assign add_ovf = (rs_val[DATA_W-1] == imm_s[DATA_W-1]) && (sum[DATA_W-1] != rs_val[DATA_W-1]);

   always_comb begin
      op      = decode_op(opcode);
      illegal = (op == OP_ILL) || (int'(rs) >= NUM_REGS) || (int'(rt) >= NUM_REGS);
      res_c   = '0;
      wen_c   = 1'b0;
      taken_c = 1'b0;
      ovf_c   = 1'b0;
      carry_c = 1'b0;
      if (!illegal) begin
         case (op)
            OP_ADD: begin
               res_c   = sum[DATA_W-1:0];
               carry_c = sum[DATA_W];
               ovf_c   = add_ovf;
               wen_c   = !add_ovf;
            end
            OP_ADDU: begin
               res_c   = sum[DATA_W-1:0];
               carry_c = sum[DATA_W];
               wen_c   = 1'b1;
            end
            OP_SLT: begin
               res_c = DATA_W'($signed(rs_val) < $signed(imm_s));
               wen_c = 1'b1;
            end
            OP_SLTU: begin
               res_c = DATA_W'(rs_val < imm_s);
               wen_c = 1'b1;
            end
            OP_AND: begin res_c = rs_val & imm_z; wen_c = 1'b1; end
            OP_OR:  begin res_c = rs_val | imm_z; wen_c = 1'b1; end
            OP_XOR: begin res_c = rs_val ^ imm_z; wen_c = 1'b1; end
            OP_LUI: begin res_c = lui_val;        wen_c = 1'b1; end
            OP_BEQ: begin res_c = imm_s << 2; taken_c = (rs_val == rt_val); end
            OP_BNE: begin res_c = imm_s << 2; taken_c = (rs_val != rt_val); end
            default: ;
         endcase
      end
      status_c            = '0;
      status_c[ST_ZERO]   = (res_c == '0);
      status_c[ST_NEG]    = res_c[DATA_W-1];
      status_c[ST_OVF]    = ovf_c;
      status_c[ST_CARRY]  = carry_c;
      status_c[ST_TAKEN]  = taken_c;
      status_c[ST_ILL]    = illegal;
      status_c[ST_WR]     = wen_c && (rt != 5'd0);
      status_c[ST_STICKY] = sticky_q || ovf_c;
   end

   // An overflowing addi counts as a trap just like an illegal instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         result      <= '0;
         status      <= '0;
         sticky_q    <= 1'b0;
         retired_cnt <= '0;
         trap_cnt    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         result    <= res_c;
         status    <= status_c;
         sticky_q  <= sticky_q || ovf_c;
         if (illegal || ovf_c) trap_cnt    <= trap_cnt + 1'b1;
         else                  retired_cnt <= retired_cnt + 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_imm_exec_unit.sv
// Directed bench: a vector table through the default unit, then backpressure,
// small-register-file illegal index and asynchronous reset sequences.
module tb_mips_imm_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready, in_ready, out_valid;
   logic [31:0] machinecode, result, dbg_data;
   logic [7:0]  status;
   logic [15:0] retired_cnt, trap_cnt;
   logic [4:0]  dbg_addr;

   logic        in_valid8, out_ready8, in_ready8, out_valid8;
   logic [31:0] machinecode8, result8, dbg_data8;
   logic [7:0]  status8;
   logic [15:0] retired_cnt8, trap_cnt8;
   logic [4:0]  dbg_addr8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mips_imm_exec_unit u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .machinecode(machinecode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .status(status), .retired_cnt(retired_cnt),
      .trap_cnt(trap_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   mips_imm_exec_unit #(.NUM_REGS(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .machinecode(machinecode8), .out_valid(out_valid8), .out_ready(out_ready8),
      .result(result8), .status(status8), .retired_cnt(retired_cnt8),
      .trap_cnt(trap_cnt8), .dbg_addr(dbg_addr8), .dbg_data(dbg_data8)
   );

   typedef struct {
      string       name;
      logic [31:0] mc;
      logic [31:0] res;
      logic [7:0]  st;
      logic [4:0]  dbg;
      logic [31:0] dval;
      logic [15:0] ret;
      logic [15:0] trp;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] mc);
      @(negedge clk);
      machinecode = mc;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{"addi t1",      32'h20090004, 32'h00000004, 8'h40,  5'd9, 32'h00000004,  1, 0};
      vecs[1]  = '{"addi t2",      32'h200A0009, 32'h00000009, 8'h40, 5'd10, 32'h00000009,  2, 0};
      vecs[2]  = '{"beq ne",       32'h112AFFFF, 32'hFFFFFFFC, 8'h02,  5'd9, 32'h00000004,  3, 0};
      vecs[3]  = '{"bne taken",    32'h152AFFFF, 32'hFFFFFFFC, 8'h12, 5'd10, 32'h00000009,  4, 0};
      vecs[4]  = '{"lui t3",       32'h3C0B7FFF, 32'h7FFF0000, 8'h40, 5'd11, 32'h7FFF0000,  5, 0};
      vecs[5]  = '{"ori t3",       32'h356BFFFF, 32'h7FFFFFFF, 8'h40, 5'd11, 32'h7FFFFFFF,  6, 0};
      vecs[6]  = '{"addi ovf",     32'h216C0001, 32'h80000000, 8'h86, 5'd12, 32'h00000000,  6, 1};
      vecs[7]  = '{"addiu wrap",   32'h256C0001, 32'h80000000, 8'hC2, 5'd12, 32'h80000000,  7, 1};
      vecs[8]  = '{"illegal op",   32'hFC000000, 32'h00000000, 8'hA1, 5'd12, 32'h80000000,  7, 2};
      vecs[9]  = '{"slti",         32'h298DFFFF, 32'h00000001, 8'hC0, 5'd13, 32'h00000001,  8, 2};
      vecs[10] = '{"sltiu",        32'h2D8EFFFF, 32'h00000001, 8'hC0, 5'd14, 32'h00000001,  9, 2};
      vecs[11] = '{"andi",         32'h316F00F0, 32'h000000F0, 8'hC0, 5'd15, 32'h000000F0, 10, 2};
      vecs[12] = '{"xori",         32'h3970FFFF, 32'h7FFF0000, 8'hC0, 5'd16, 32'h7FFF0000, 11, 2};
      vecs[13] = '{"addiu carry0", 32'h2531FFFC, 32'h00000000, 8'hC9, 5'd17, 32'h00000000, 12, 2};
      vecs[14] = '{"addi r0",      32'h21200001, 32'h00000005, 8'h80,  5'd0, 32'h00000000, 13, 2};
      vecs[15] = '{"addi carry",   32'h2152FFFF, 32'h00000008, 8'hC8, 5'd18, 32'h00000008, 14, 2};

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; machinecode = '0; dbg_addr = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; machinecode8 = '0; dbg_addr8 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 32'(out_valid), 0);
      check("reset status", 32'(status), 0);
      check("reset result", result, 0);
      check("reset counters", {retired_cnt, trap_cnt}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset in_ready", 32'(in_ready), 1);

      foreach (vecs[i]) begin
         send(vecs[i].mc);
         dbg_addr = vecs[i].dbg;
         #1;
         check({vecs[i].name, " valid"}, 32'(out_valid), 1);
         check({vecs[i].name, " result"}, result, vecs[i].res);
         check({vecs[i].name, " status"}, 32'(status), 32'(vecs[i].st));
         check({vecs[i].name, " reg"}, dbg_data, vecs[i].dval);
         check({vecs[i].name, " retired"}, 32'(retired_cnt), 32'(vecs[i].ret));
         check({vecs[i].name, " traps"}, 32'(trap_cnt), 32'(vecs[i].trp));
      end

      // idle with consumer ready drains the output
      @(posedge clk); #1;
      check("drain out_valid", 32'(out_valid), 0);

      // backpressure: A accepted, B held for 3 cycles, then same-edge accept
      @(negedge clk);
      out_ready = 1'b0;
      send(32'h24130011);
      check("bp A result", result, 32'h11);
      @(negedge clk);
      machinecode = 32'h24140022;
      in_valid    = 1'b1;
      dbg_addr    = 5'd20;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("bp in_ready", 32'(in_ready), 0);
         check("bp result held", result, 32'h11);
         check("bp no write", dbg_data, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("bp ready again", 32'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp B result", result, 32'h22);
      check("bp B written", dbg_data, 32'h22);
      check("bp retired", 32'(retired_cnt), 16);

      // small register file: legal write then out-of-range rt
      @(negedge clk);
      machinecode8 = 32'h20030007; in_valid8 = 1'b1;
      @(posedge clk); #1;
      machinecode8 = 32'h20090004;
      dbg_addr8 = 5'd3; #1;
      check("r8 legal result", result8, 7);
      check("r8 legal reg", dbg_data8, 7);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      check("r8 ill result", result8, 0);
      check("r8 ill status", 32'(status8), 32'h21);
      check("r8 ill trap", 32'(trap_cnt8), 1);
      check("r8 ill retired", 32'(retired_cnt8), 1);
      check("r8 reg3 kept", dbg_data8, 7);
      dbg_addr8 = 5'd9; #1;
      check("r8 dbg oob", dbg_data8, 0);

      // async reset mid-cycle with a held output
      @(negedge clk);
      out_ready = 1'b0;
      send(32'h24150033);
      check("pre-reset valid", 32'(out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 32'(out_valid), 0);
      check("rst status", 32'(status), 0);
      check("rst counters", {retired_cnt, trap_cnt}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check("rst in_ready", 32'(in_ready), 1);
      begin
         int nz = 0;
         for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r);
            #1;
            if (dbg_data != 0) nz++;
         end
         check("rst regs zero", 32'(nz), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
